// File: rtl/xoshiro128_stream.sv
// xoshiro128 stream generator: one state engine, run-time scrambler select
// (++, **, +), prefetch FIFO with valid/ready output and a 128-cycle jump().
//
// Parameters
//   FIFO_DEPTH  prefetch entries (power of two, 2..16)
//   SEED0..3    reset value of state words s0..s3
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   mode                  scrambler: 0 ++, 1 **, 2 +, 3 ++
//   write/_addr/_data     overwrite state word s[write_addr], flushes FIFO
//   jump_start            start jump(); ignored while busy
//   out_valid/ready/data  output stream handshake, out_data is the FIFO head
//   busy                  jump in progress
//   level                 FIFO occupancy
module xoshiro128_stream #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] SEED0      = 32'h2C981311,
    parameter logic [31:0] SEED1      = 32'hF012F489,
    parameter logic [31:0] SEED2      = 32'h4826A2A8,
    parameter logic [31:0] SEED3      = 32'hC0910824
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    mode,
    input  logic                          write,
    input  logic [1:0]                    write_addr,
    input  logic [31:0]                   write_data,
    input  logic                          jump_start,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    // Jump polynomial, word 0 in the low bits so bit i is JUMP_BITS[i].
    localparam logic [127:0] JUMP_BITS = {32'h77f2db5b, 32'h6fa035c3,
                                          32'hf542d2d3, 32'h8764000b};

    // Registered state
    logic [31:0]    s      [4];
    logic [31:0]    acc    [4];
    logic [31:0]    mem    [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [LW-1:0]  count;
    logic [6:0]     jcnt;
    logic           busy_q;
    logic           valid_q;
    logic [31:0]    head_q;

    // Next-state values
    logic [31:0]    s_n    [4];
    logic [31:0]    acc_n  [4];
    logic [31:0]    mem_n  [FIFO_DEPTH];
    logic [AW-1:0]  rd_n;
    logic [AW-1:0]  wr_n;
    logic [LW-1:0]  count_n;
    logic [6:0]     jcnt_n;
    logic           busy_n;
    logic           valid_n;
    logic [31:0]    head_n;

    // Helpers
    logic [31:0]    st     [4];
    logic [31:0]    word;
    logic [31:0]    sum;
    logic [31:0]    sum_rot;
    logic [31:0]    m5;
    logic [31:0]    m5_rot;
    logic [31:0]    t2;
    logic [31:0]    t3;
    logic           jbit;
    logic           full;
    logic           pop_c;
    logic           gen_c;

    assign out_valid = valid_q;
    assign out_data  = head_q;
    assign busy      = busy_q;
    assign level     = count;

    // Next state: write > jump step > jump start > stream push/pop
    always_comb begin
        s_n     = s;
        acc_n   = acc;
        mem_n   = mem;
        rd_n    = rd_ptr;
        wr_n    = wr_ptr;
        count_n = count;
        jcnt_n  = jcnt;
        busy_n  = busy_q;
        jbit    = JUMP_BITS[jcnt];

        // One xoshiro128 state step from the current s
        t2    = s[2] ^ s[0];
        t3    = s[3] ^ s[1];
        st[1] = s[1] ^ t2;
        st[0] = s[0] ^ t3;
        st[2] = t2 ^ {s[1][22:0], 9'b0};
        st[3] = {t3[20:0], t3[31:21]};

        // Scrambled output of the current s
        sum     = s[0] + s[3];
        sum_rot = {sum[24:0], sum[31:25]};
        m5      = s[1] + {s[1][29:0], 2'b00};
        m5_rot  = {m5[24:0], m5[31:25]};
        case (mode)
            2'd1:    word = m5_rot + {m5_rot[28:0], 3'b000};
            2'd2:    word = sum;
            default: word = sum_rot + s[0];
        endcase

        full  = (count == LW'(FIFO_DEPTH));
        pop_c = valid_q && out_ready;
        gen_c = !busy_q && !jump_start && (!full || pop_c);

        if (write) begin
            s_n[write_addr] = write_data;
            rd_n    = '0;
            wr_n    = '0;
            count_n = '0;
            busy_n  = 1'b0;
        end else if (busy_q) begin
            if (jcnt == 7'd127) begin
                // Final bit folds the pre-step state straight into s
                for (int k = 0; k < 4; k++) begin
                    s_n[k] = acc[k] ^ (jbit ? s[k] : 32'h0);
                end
                busy_n = 1'b0;
            end else begin
                if (jbit) begin
                    for (int k = 0; k < 4; k++) begin
                        acc_n[k] = acc[k] ^ s[k];
                    end
                end
                s_n    = st;
                jcnt_n = 7'(jcnt + 7'd1);
            end
        end else if (jump_start) begin
            busy_n  = 1'b1;
            jcnt_n  = '0;
            acc_n   = '{default: 32'h0};
            rd_n    = '0;
            wr_n    = '0;
            count_n = '0;
        end else begin
            if (pop_c) begin
                rd_n = AW'(rd_ptr + 1'b1);
            end
            if (gen_c) begin
                mem_n[wr_ptr] = word;
                wr_n          = AW'(wr_ptr + 1'b1);
                s_n           = st;
            end
            if (gen_c && !pop_c) begin
                count_n = LW'(count + 1'b1);
            end else if (!gen_c && pop_c) begin
                count_n = LW'(count - 1'b1);
            end
        end

        // Head and valid are registered from their next-state values
        valid_n = (count_n != '0);
        head_n  = mem_n[rd_n];
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s       <= '{SEED0, SEED1, SEED2, SEED3};
            acc     <= '{default: 32'h0};
            mem     <= '{default: 32'h0};
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            jcnt    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            s       <= s_n;
            acc     <= acc_n;
            mem     <= mem_n;
            rd_ptr  <= rd_n;
            wr_ptr  <= wr_n;
            count   <= count_n;
            jcnt    <= jcnt_n;
            busy_q  <= busy_n;
            valid_q <= valid_n;
            head_q  <= head_n;
        end
    end

endmodule
